ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 5-stage WISC pipeline, directly downstream of the execute stage.
- Captures execute results (ALU/LBI/SLBI result, store data, resolved next PC) and the MEM/WB control bundle of one instruction per cycle, then presents them to the memory stage.
- Supports stall (hold), flush (bubble insertion), a valid bit, a sticky halt latch and a one-cycle forwarding tap for the hazard unit.

Parameters:
- DW, 16, datapath width (results, store data, PC).
- RW, 3, register-specifier width (8 GPRs).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  memory stage busy; hold all contents.
- flush  in  1  squash the instruction currently leaving EX; load a bubble.
- ex_valid  in  1  EX holds a real instruction.
- ex_alu_result  in  DW  ALU_Result_out from execute.
- ex_store_data  in  DW  read_data_2 forwarded for ST/STU.
- ex_next_pc  in  DW  resolved next PC (branch/jump target or PC+2).
- ex_write_reg  in  RW  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_halt  in  1 each  control bundle.
- ex_err  in  1  execute-stage error.
- mem_valid  out  1  registered valid.
- mem_alu_result, mem_store_data, mem_next_pc  out  DW  registered copies.
- mem_write_reg  out  RW  registered copy.
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_halt  out  1 each  registered, gated by valid (see below).
- mem_err  out  1  registered error, sticky.
- fwd_en  out  1  combinational: mem_valid & mem_reg_write & ~mem_mem_read.
- fwd_reg  out  RW  equals mem_write_reg.
- fwd_val  out  DW  equals mem_alu_result.
- halt_seen  out  1  sticky: a valid halt has been captured.

Behaviour:
- Reset (rst=1 at edge): every registered output 0, including mem_valid, mem_err and halt_seen. Forwarding outputs are therefore 0. Reset has priority over everything.
- Update priority per edge: rst > stall > flush > load.
  - stall=1: all registers keep their value, including with flush=1. The held instruction is older than the squashed one, and the squash is re-requested by the hazard unit.
  - flush=1, stall=0: mem_valid=0; all control outputs 0; data registers may load but are don't-care. mem_err keeps its sticky value.
  - load: all fields take the ex_* values. mem_valid <= ex_valid & ~halt_seen.
- Control gating: control registers load (ex_ctrl & ex_valid & ~halt_seen). An invalid slot never asserts reg_write, mem_read, mem_write or halt.
- Halt:
  - halt_seen sets when a valid ex_halt is loaded and stays set until rst.
  - While halt_seen=1, later loads are bubbles (valid 0, controls 0).
  - stall still holds the halt instruction itself.
- Error: mem_err <= mem_err | (ex_err & ex_valid) on load; it holds on stall and flush.
- Latency: exactly 1 cycle from EX to MEM when stall=0. No combinational path from any ex_* input to any output.
- Stall sequences:
  - A stall of N cycles keeps the outputs constant for N cycles.
  - The first non-stall edge loads the current ex_* values.
- Width rules: pure pass-through, no arithmetic. RW/DW are fixed per instance.

Decomposition:
- Shared header (global `define include): DW=16, RW=3, control-bundle bit positions. The hazard unit and the other pipeline registers use the same bundle layout.
- One natural sub-module: reg_en (parameterised width, synchronous active-high reset, enable, synchronous clear). It is instantiated once per field group: data, control, valid; halt_seen and mem_err use dedicated set logic.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_valid=1 and all ex_* nonzero -> all outputs 0, fwd_en=0. Release with ex_alu_result=16'h1234, ex_reg_write=1, ex_write_reg=3'd5, ex_valid=1 -> next cycle mem_alu_result=16'h1234, fwd_en=1, fwd_reg=5.
- Stall hold: load ADD result 16'h00FF, then stall=1 for 3 cycles while ex_alu_result changes to 16'hAAAA -> outputs stay 16'h00FF. On the first stall=0 edge the output becomes 16'hAAAA.
- Flush: load ST with ex_mem_write=1, ex_store_data=16'hBEEF, flush=1 -> mem_valid=0, mem_mem_write=0. Repeat with stall=1 and flush=1 -> the prior instruction is held unchanged.
- Load hazard tap: ex_mem_read=1, ex_reg_write=1, ex_write_reg=2 -> fwd_en=0, mem_mem_read=1.
- Halt: load valid ex_halt=1 -> mem_halt=1, halt_seen=1. The next 3 loads with ex_valid=1, ex_reg_write=1 -> mem_valid=0, mem_reg_write=0. halt_seen clears only after rst.
- Error and invalid gating: ex_err=1 with ex_valid=1 -> mem_err=1 and stays 1 through later clean loads. Separately, ex_err=1 with ex_valid=0 from reset -> mem_err stays 0.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// Shared definitions for the WISC EX/MEM pipeline register: datapath widths
// and the MEM/WB control-bundle layout used by the pipeline registers and
// the hazard unit.
package ex_mem_reg_pkg;

    localparam int WISC_DW = 16;
    localparam int WISC_RW = 3;

    // Control bundle bit positions (MSB first)
    localparam int CTRL_W          = 5;
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_HALT       = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // An invalid or squashed slot must never carry live control bits
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic keep);
        gate_ctrl = keep ? c : '0;
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX -> MEM bus: execute-stage results in, memory-stage view and hazard
// forwarding tap out.
interface ex_mem_reg_if
    import ex_mem_reg_pkg::*;
#(
    parameter int DW = WISC_DW,
    parameter int RW = WISC_RW
);
    logic          ex_valid;
    logic [DW-1:0] ex_alu_result;
    logic [DW-1:0] ex_store_data;
    logic [DW-1:0] ex_next_pc;
    logic [RW-1:0] ex_write_reg;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic          ex_halt;
    logic          ex_err;

    logic          mem_valid;
    logic [DW-1:0] mem_alu_result;
    logic [DW-1:0] mem_store_data;
    logic [DW-1:0] mem_next_pc;
    logic [RW-1:0] mem_write_reg;
    logic          mem_reg_write;
    logic          mem_mem_read;
    logic          mem_mem_write;
    logic          mem_mem_to_reg;
    logic          mem_halt;
    logic          mem_err;

    logic          fwd_en;
    logic [RW-1:0] fwd_reg;
    logic [DW-1:0] fwd_val;
    logic          halt_seen;

    // Execute side drives ex_*, observes the registered stage
    modport master (
        output ex_valid, ex_alu_result, ex_store_data, ex_next_pc, ex_write_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_halt, ex_err,
        input  mem_valid, mem_alu_result, mem_store_data, mem_next_pc, mem_write_reg,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_halt,
               mem_err, fwd_en, fwd_reg, fwd_val, halt_seen
    );

    // The pipeline register itself
    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data, ex_next_pc, ex_write_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_halt, ex_err,
        output mem_valid, mem_alu_result, mem_store_data, mem_next_pc, mem_write_reg,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_halt,
               mem_err, fwd_en, fwd_reg, fwd_val, halt_seen
    );

endinterface

// File: rtl/ex_mem_reg_reg_en.sv
// Generic pipeline field register: synchronous reset, enable (hold when low)
// and synchronous clear that only acts on enabled edges.
module reg_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset beats hold, hold beats clear, clear beats load
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            if (clr) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the 5-stage WISC pipeline. Holds on stall,
// inserts a bubble on flush, turns everything after a captured halt into
// bubbles, and exposes a forwarding tap for the hazard unit.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DW = WISC_DW,
    parameter int RW = WISC_RW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    ex_mem_reg_if.slave  bus
);

    localparam int DATA_W = 3 * DW + RW;

    logic              advance;
    logic              load_live;
    ctrl_t             ex_ctrl;
    ctrl_t             ctrl_d;
    ctrl_t             ctrl_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              halt_seen_q;
    logic              err_q;

    assign advance   = ~stall;
    assign load_live = bus.ex_valid & ~halt_seen_q;
    assign ctrl_d    = gate_ctrl(ex_ctrl, load_live);
    assign data_d    = {bus.ex_alu_result, bus.ex_store_data, bus.ex_next_pc, bus.ex_write_reg};

    // Pack the individual control inputs into the shared bundle layout
    always_comb begin
        ex_ctrl                  = '0;
        ex_ctrl[CTRL_REG_WRITE]  = bus.ex_reg_write;
        ex_ctrl[CTRL_MEM_READ]   = bus.ex_mem_read;
        ex_ctrl[CTRL_MEM_WRITE]  = bus.ex_mem_write;
        ex_ctrl[CTRL_MEM_TO_REG] = bus.ex_mem_to_reg;
        ex_ctrl[CTRL_HALT]       = bus.ex_halt;
    end

    // Data is don't-care in a bubble, so it is never cleared by flush
    reg_en #(.W(DATA_W)) u_data (
        .clk (clk), .rst (rst), .en (advance), .clr (1'b0), .d (data_d), .q (data_q)
    );

    reg_en #(.W(CTRL_W)) u_ctrl (
        .clk (clk), .rst (rst), .en (advance), .clr (flush), .d (ctrl_d), .q (ctrl_q)
    );

    reg_en #(.W(1)) u_valid (
        .clk (clk), .rst (rst), .en (advance), .clr (flush), .d (load_live), .q (valid_q)
    );

    // Sticky halt: set by the first valid halt that actually enters MEM
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_seen_q <= 1'b0;
        end else if (advance && !flush && load_live && bus.ex_halt) begin
            halt_seen_q <= 1'b1;
        end
    end

    // Sticky error: accumulates on loads, untouched by stall and flush
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (advance && !flush) begin
            err_q <= err_q | (bus.ex_err & bus.ex_valid);
        end
    end

    assign bus.mem_valid = valid_q;
    assign {bus.mem_alu_result, bus.mem_store_data, bus.mem_next_pc, bus.mem_write_reg} = data_q;
    assign bus.mem_reg_write  = ctrl_q[CTRL_REG_WRITE];
    assign bus.mem_mem_read   = ctrl_q[CTRL_MEM_READ];
    assign bus.mem_mem_write  = ctrl_q[CTRL_MEM_WRITE];
    assign bus.mem_mem_to_reg = ctrl_q[CTRL_MEM_TO_REG];
    assign bus.mem_halt       = ctrl_q[CTRL_HALT];
    assign bus.mem_err        = err_q;
    assign bus.halt_seen      = halt_seen_q;

    // Loads are not forwardable from MEM; their data is not ready yet
    assign bus.fwd_en  = valid_q & ctrl_q[CTRL_REG_WRITE] & ~ctrl_q[CTRL_MEM_READ];
    assign bus.fwd_reg = data_q[RW-1:0];
    assign bus.fwd_val = data_q[DATA_W-1 -: DW];

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios then random traffic,
// with a behavioural model feeding a scoreboard queue that a separate monitor
// drains and compares every cycle.
module tb_ex_mem_reg;

    logic clk;
    logic rst;
    logic stall;
    logic flush;

    ex_mem_reg_if bus ();

    ex_mem_reg dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [15:0] npc;
        logic [2:0]  wreg;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        halt;
        logic        err;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [15:0] npc;
        logic [2:0]  wreg;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        halt;
        logic        err;
        logic        halt_seen;
        logic        data_known;
    } model_t;

    model_t ref_state;
    model_t exp_q[$];
    int     n_compared = 0;
    int     n_failed   = 0;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Architectural meaning of one clock edge, written from the stage rules
    function automatic model_t model_step(input model_t m, input stim_t s);
        model_t n;
        logic   real_insn;
        n = m;
        if (s.rst) begin
            n = '0;
            n.data_known = 1'b1;
        end else if (s.stall) begin
            n = m;
        end else if (s.flush) begin
            n.valid = 1'b0;
            n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.m2r = 1'b0; n.halt = 1'b0;
            n.data_known = 1'b0;
        end else begin
            real_insn    = s.valid && !m.halt_seen;
            n.valid      = real_insn;
            n.alu        = s.alu;
            n.sd         = s.sd;
            n.npc        = s.npc;
            n.wreg       = s.wreg;
            n.data_known = 1'b1;
            n.rw         = real_insn ? s.rw   : 1'b0;
            n.mr         = real_insn ? s.mr   : 1'b0;
            n.mw         = real_insn ? s.mw   : 1'b0;
            n.m2r        = real_insn ? s.m2r  : 1'b0;
            n.halt       = real_insn ? s.halt : 1'b0;
            if (s.valid && s.err) n.err = 1'b1;
            if (real_insn && s.halt) n.halt_seen = 1'b1;
        end
        return n;
    endfunction

    // Drive one cycle of stimulus away from the active edge and queue its effect
    task automatic apply_stimulus(input stim_t s);
        @(negedge clk);
        rst                = s.rst;
        stall              = s.stall;
        flush              = s.flush;
        bus.ex_valid       = s.valid;
        bus.ex_alu_result  = s.alu;
        bus.ex_store_data  = s.sd;
        bus.ex_next_pc     = s.npc;
        bus.ex_write_reg   = s.wreg;
        bus.ex_reg_write   = s.rw;
        bus.ex_mem_read    = s.mr;
        bus.ex_mem_write   = s.mw;
        bus.ex_mem_to_reg  = s.m2r;
        bus.ex_halt        = s.halt;
        bus.ex_err         = s.err;
        ref_state = model_step(ref_state, s);
        exp_q.push_back(ref_state);
    endtask

    // Monitor: after every active edge, compare the stage against the oldest expectation
    initial begin
        model_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("mem_valid",      64'(bus.mem_valid),      64'(e.valid));
                check_output("mem_reg_write",  64'(bus.mem_reg_write),  64'(e.rw));
                check_output("mem_mem_read",   64'(bus.mem_mem_read),   64'(e.mr));
                check_output("mem_mem_write",  64'(bus.mem_mem_write),  64'(e.mw));
                check_output("mem_mem_to_reg", 64'(bus.mem_mem_to_reg), 64'(e.m2r));
                check_output("mem_halt",       64'(bus.mem_halt),       64'(e.halt));
                check_output("mem_err",        64'(bus.mem_err),        64'(e.err));
                check_output("halt_seen",      64'(bus.halt_seen),      64'(e.halt_seen));
                check_output("fwd_en",         64'(bus.fwd_en),         64'(e.valid & e.rw & ~e.mr));
                if (e.data_known) begin
                    check_output("mem_alu_result", 64'(bus.mem_alu_result), 64'(e.alu));
                    check_output("mem_store_data", 64'(bus.mem_store_data), 64'(e.sd));
                    check_output("mem_next_pc",    64'(bus.mem_next_pc),    64'(e.npc));
                    check_output("mem_write_reg",  64'(bus.mem_write_reg),  64'(e.wreg));
                    check_output("fwd_reg",        64'(bus.fwd_reg),        64'(e.wreg));
                    check_output("fwd_val",        64'(bus.fwd_val),        64'(e.alu));
                end
            end
        end
    end

    // Directed scenarios, random traffic, drain, summary
    initial begin
        stim_t s;
        int    waited;

        ref_state = '0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_alu_result = '0; bus.ex_store_data = '0;
        bus.ex_next_pc = '0; bus.ex_write_reg = '0; bus.ex_reg_write = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0; bus.ex_mem_to_reg = 1'b0;
        bus.ex_halt = 1'b0; bus.ex_err = 1'b0;

        // Reset with busy, nonzero inputs
        s = '1;
        s.stall = 1'b0; s.flush = 1'b0;
        apply_stimulus(s);
        apply_stimulus(s);

        // First instruction after reset, forwardable
        s = idle_stim();
        s.valid = 1'b1; s.alu = 16'h1234; s.rw = 1'b1; s.wreg = 3'd5; s.npc = 16'h0002;
        apply_stimulus(s);

        // Stall hold: load 00FF, then 3 stalled cycles with new data
        s.alu = 16'h00FF; s.wreg = 3'd1; s.npc = 16'h0004;
        apply_stimulus(s);
        s.alu = 16'hAAAA; s.stall = 1'b1;
        repeat (3) apply_stimulus(s);
        s.stall = 1'b0;
        apply_stimulus(s);

        // Flush a store
        s = idle_stim();
        s.valid = 1'b1; s.mw = 1'b1; s.sd = 16'hBEEF; s.alu = 16'h0010; s.flush = 1'b1;
        apply_stimulus(s);
        // Load a real store, then stall+flush must hold it
        s.flush = 1'b0;
        apply_stimulus(s);
        s.stall = 1'b1; s.flush = 1'b1; s.sd = 16'h5555; s.mw = 1'b0; s.rw = 1'b1;
        apply_stimulus(s);

        // Load-use hazard tap
        s = idle_stim();
        s.valid = 1'b1; s.mr = 1'b1; s.rw = 1'b1; s.m2r = 1'b1; s.wreg = 3'd2; s.alu = 16'h0040;
        apply_stimulus(s);

        // Error is sticky through clean loads and flushes
        s = idle_stim();
        s.valid = 1'b1; s.err = 1'b1; s.rw = 1'b1; s.wreg = 3'd3;
        apply_stimulus(s);
        s.err = 1'b0; s.alu = 16'h0101;
        apply_stimulus(s);
        s.flush = 1'b1;
        apply_stimulus(s);
        s.flush = 1'b0;
        apply_stimulus(s);

        // Halt, then held by stall, then later loads become bubbles
        s = idle_stim();
        s.valid = 1'b1; s.halt = 1'b1; s.npc = 16'h0020;
        apply_stimulus(s);
        s.halt = 1'b0; s.stall = 1'b1; s.rw = 1'b1; s.wreg = 3'd4; s.alu = 16'h7777;
        apply_stimulus(s);
        s.stall = 1'b0;
        repeat (3) apply_stimulus(s);

        // Reset clears halt_seen; invalid error must not stick
        s = idle_stim();
        s.rst = 1'b1;
        apply_stimulus(s);
        s = idle_stim();
        s.err = 1'b1; s.valid = 1'b0; s.alu = 16'h0F0F;
        apply_stimulus(s);
        apply_stimulus(s);
        s.valid = 1'b1; s.err = 1'b0; s.rw = 1'b1; s.wreg = 3'd6;
        apply_stimulus(s);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            s.rst   = ($urandom_range(0, 29) == 0);
            s.stall = ($urandom_range(0, 3) == 0);
            s.flush = ($urandom_range(0, 5) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.alu   = 16'($urandom());
            s.sd    = 16'($urandom());
            s.npc   = 16'($urandom());
            s.wreg  = 3'($urandom());
            s.rw    = 1'($urandom());
            s.mr    = 1'($urandom());
            s.mw    = 1'($urandom());
            s.m2r   = 1'($urandom());
            s.halt  = ($urandom_range(0, 24) == 0);
            s.err   = ($urandom_range(0, 19) == 0);
            apply_stimulus(s);
        end

        // Bounded drain of the scoreboard
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        n_compared++;
        if (exp_q.size() != 0) begin
            n_failed++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
